hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It sits beside the decode stage and watches decode source registers, the EX-stage load, the decode branch/jump redirect and the data-memory handshake. From these it generates the stall, bubble and flush controls for fetch, decode and execute. It also owns a memory-wait timeout that halts the pipeline on a hung memory.

Parameters:
REG_AW, 3, register address width (8 GPRs)
MEM_TIMEOUT, 15, max consecutive MemReq-without-MemReady cycles before halt (1..255)

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
IdValid  in  1  decode holds a valid instruction
IdRs  in  REG_AW  decode source 1 (Instruct[10:8])
IdRsUsed  in  1  source 1 is read by this instruction
IdRt  in  REG_AW  decode source 2 (Instruct[7:5])
IdRtUsed  in  1  source 2 is read
IdRedirect  in  1  decode resolved taken branch or jump
ExValid  in  1  EX stage holds a valid instruction
ExLoad  in  1  EX instruction is a load
ExRd  in  REG_AW  EX destination register
ExWrEn  in  1  EX instruction writes the register file
MemReq  in  1  MEM stage access in progress
MemReady  in  1  data memory completes access this cycle
StallF  out  1  hold PC/fetch register
StallD  out  1  hold decode register (drives decode Stall)
StallE  out  1  hold EX/MEM registers
BubbleE  out  1  load NOP into ID/EX register
FlushF  out  1  squash the instruction in fetch (IF/ID becomes NOP)
Halted  out  1  sticky memory-timeout halt
State  out  2  FSM state, for debug

Behaviour:
- State register: RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2; 2'd3 is illegal and decodes to RUN. Timeout counter is 8 bits.
- Outputs are combinational from the current state and inputs (Mealy). State and counter are registered.
- Reset (rst=0, asynchronous): State=RUN, counter=0, Halted=0. All outputs are 0 while rst is low.
- Load-use hazard LU = ExValid & ExLoad & ExWrEn & IdValid & ((IdRsUsed & IdRs==ExRd) | (IdRtUsed & IdRt==ExRd)). r0 is not special. The WB→ID hazard is covered by register-file bypass, so no stall is needed for it.
- MemStall = MemReq & ~MemReady.
- RUN state, priority MemStall > LU > IdRedirect:
  - MemStall: StallF=StallD=StallE=1, BubbleE=0, FlushF=0. Next state MEM_WAIT, counter=1.
  - LU (no MemStall): StallF=StallD=1, BubbleE=1, StallE=0, FlushF=0. Lasts exactly one cycle, since the load advances and LU drops. State stays RUN.
  - IdRedirect (no MemStall, no LU): FlushF=1 for that cycle, all stalls 0. A redirect that coincides with a stall is not lost: decode is held, so IdRedirect re-presents and is honoured in the first unstalled cycle.
  - Otherwise all outputs are 0.
- MEM_WAIT state:
  - StallF=StallD=StallE=1 and BubbleE=0 while MemStall.
  - MemReady=1 releases in the same cycle: stalls drop and RUN rules apply combinationally to LU/IdRedirect. Next state RUN, counter=0.
  - MemStall with counter==MEM_TIMEOUT: next state HALT, Halted=1. Otherwise counter increments.
  - MemReq dropping without MemReady is treated as a release.
- HALT state: StallF=StallD=StallE=1, BubbleE=0, FlushF=0. It is left only by reset.
- Counter never wraps; it is bounded by the MEM_TIMEOUT compare.
- Reset asserted mid-stall clears everything immediately, with no output glitch ordering requirement.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds outputs StallCycles[15:0] and FlushCount[15:0]. Both reset to 0, saturate at 16'hFFFF and are cleared by reset only.
  - StallCycles increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with FlushF=1.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

Test Plan:
1. Reset then idle: rst low for 3 cycles, release with all inputs 0 → all outputs 0, State=0.
2. Load-use: ExValid=ExLoad=ExWrEn=1, ExRd=3, IdValid=1, IdRs=3, IdRsUsed=1 for one cycle, then ExLoad=0 → StallF=StallD=BubbleE=1 for exactly 1 cycle, StallE=0. Repeat with IdRsUsed=0 and IdRt=4 → no stall.
3. Redirect during load-use: same as test 2 plus IdRedirect=1 held for 2 cycles → cycle 1 stall with FlushF=0; cycle 2 FlushF=1 with no stalls.
4. Memory wait: MemReq=1, MemReady=0 for 5 cycles, then MemReady=1 → StallF/D/E=1 for 5 cycles, State=1; release cycle all stalls 0, State returns to 0, Halted=0.
5. Timeout: MEM_TIMEOUT=4, MemReq=1, MemReady never asserted → State goes to 2 and Halted=1 on the 5th edge, stalls held. A later MemReady=1 has no effect; rst low clears it to RUN.
6. Priority: MemStall, LU and IdRedirect asserted together in RUN → StallE=1, BubbleE=0, FlushF=0. With HAZARD_PERF_EN, StallCycles counts every stalled cycle exactly.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : stall / bubble / flush sequencing for the 5-stage pipeline,
//               with a memory-wait timeout that halts on a hung data memory.
// Optional feature macro: HAZARD_PERF_EN (StallCycles / FlushCount counters)
// Revision   : 1.0
// ============================================================================
module hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [REG_AW-1:0] IdRs,
  input  logic              IdRsUsed,
  input  logic [REG_AW-1:0] IdRt,
  input  logic              IdRtUsed,
  input  logic              IdRedirect,
  input  logic              ExValid,
  input  logic              ExLoad,
  input  logic [REG_AW-1:0] ExRd,
  input  logic              ExWrEn,
  input  logic              MemReq,
  input  logic              MemReady,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              BubbleE,
  output logic              FlushF,
  output logic              Halted,
  output logic [1:0]        State
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]       StallCycles,
  output logic [15:0]       FlushCount
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       load_use, mem_stall, run_rules;
  logic       stall_f, stall_d, stall_e, bubble_e, flush_f;

  assign load_use  = ExValid & ExLoad & ExWrEn & IdValid &
                     ((IdRsUsed & (IdRs == ExRd)) | (IdRtUsed & (IdRt == ExRd)));
  assign mem_stall = MemReq & ~MemReady;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    run_rules    = 1'b0;
    stall_f      = 1'b0;
    stall_d      = 1'b0;
    stall_e      = 1'b0;
    bubble_e     = 1'b0;
    flush_f      = 1'b0;
    case (state)
      HALT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          if (wait_cnt == TIMEOUT) begin
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + 8'd1;
          end
        end else begin
          // Release (ready, or request withdrawn): hazards apply this same cycle
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          run_rules    = 1'b1;
        end
      end
      default: begin
        // RUN, and the unused encoding which behaves as RUN
        if (mem_stall) begin
          stall_f      = 1'b1;
          stall_d      = 1'b1;
          stall_e      = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
          run_rules    = 1'b1;
        end
      end
    endcase
    if (run_rules) begin
      stall_f  = load_use;
      stall_d  = load_use;
      bubble_e = load_use;
      flush_f  = ~load_use & IdRedirect;
    end
  end

  // Outputs forced low for as long as reset is held
  assign StallF  = rst & stall_f;
  assign StallD  = rst & stall_d;
  assign StallE  = rst & stall_e;
  assign BubbleE = rst & bubble_e;
  assign FlushF  = rst & flush_f;
  assign Halted  = rst & (state == HALT);
  assign State   = rst ? state : 2'd0;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCycles <= 16'd0;
      FlushCount  <= 16'd0;
    end else begin
      if (StallD && (StallCycles != 16'hFFFF)) StallCycles <= StallCycles + 16'd1;
      if (FlushF && (FlushCount != 16'hFFFF))  FlushCount  <= FlushCount + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
